ieeedrv_sdreq: RTL and testbench

IEEEDRV_SDREQ -- requirements
Module: ieeedrv_sdreq

---
 rtl/ieeedrv_pkg.sv | 14 +
 rtl/ieeedrv_rrarb.sv | 47 ++++
 rtl/ieeedrv_sdreq.sv | 157 +++++++++++++++
 tb/tb_ieeedrv_sdreq.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ieeedrv_pkg.sv
// Shared types and constants for the IEEE drive SD image request path.
package ieeedrv_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StXfer,
    StDone
  } sdreq_state_e;

  localparam int unsigned BlkBytes    = 256;
  localparam logic [7:0]  BlkLastByte = 8'(BlkBytes - 1);

endpackage

// File: rtl/ieeedrv_rrarb.sv
// Round-robin arbiter: one-hot grant, priority pointer advances past the last winner.
module ieeedrv_rrarb #(
  parameter int unsigned N = 2
) (
  input  logic         clk_sys,
  input  logic         reset_n,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] grant
);

  // One-hot pointer to the drive holding highest priority.
  logic [N-1:0] ptr_q, ptr_d;
  logic         found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int unsigned off = 0; off < N; off++) begin
      for (int unsigned k = 0; k < N; k++) begin
        if (ptr_q[k] && !found && req[(k + off) % N]) begin
          grant[(k + off) % N] = 1'b1;
          found                = 1'b1;
        end
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (advance && found) begin
      ptr_d = '0;
      for (int unsigned k = 0; k < N; k++) begin
        ptr_d[(k + 1) % N] = grant[k];
      end
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q <= N'(1);
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/ieeedrv_sdreq.sv
// Arbitrates per-drive SD image requests onto one host port and steers
// host read bytes into the granted drive's track buffer.
module ieeedrv_sdreq
  import ieeedrv_pkg::*;
#(
  parameter  int unsigned SUBDRV = 2,
  localparam int unsigned NS     = SUBDRV - 1
) (
  input  logic          clk_sys,
  input  logic          reset_n,
  input  logic [31:0]   req_lba     [SUBDRV],
  input  logic [5:0]    req_blk_cnt [SUBDRV],
  input  logic [NS:0]   req_rd,
  input  logic [NS:0]   req_wr,
  output logic [NS:0]   req_ack,
  output logic [31:0]   sd_lba,
  output logic [5:0]    sd_blk_cnt,
  output logic [NS:0]   sd_rd,
  output logic [NS:0]   sd_wr,
  input  logic [NS:0]   sd_ack,
  input  logic [7:0]    sd_buff_addr,
  input  logic          sd_buff_wr,
  output logic [13:0]   buf_addr,
  output logic          buf_we,
  output logic [NS:0]   buf_sel,
  output logic          busy
);

  sdreq_state_e state_q, state_d;
  logic [NS:0]  grant_q, grant_d;
  logic         is_wr_q, is_wr_d;
  logic [5:0]   blk_idx_q, blk_idx_d;
  logic [31:0]  lba_q, lba_d;
  logic [5:0]   cnt_q, cnt_d;
  logic [7:0]   addr_prev_q, addr_prev_d;

  logic [NS:0]  arb_req, arb_grant;
  logic [31:0]  sel_lba;
  logic [5:0]   sel_cnt;
  logic         ack_g, pending, active, wrap;
  logic [5:0]   blk_eff;

  assign arb_req = req_rd | req_wr;

  ieeedrv_rrarb #(
    .N (SUBDRV)
  ) u_rrarb (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .req     (arb_req),
    .advance (state_q == StIdle),
    .grant   (arb_grant)
  );

  always_comb begin
    sel_lba = '0;
    sel_cnt = '0;
    for (int unsigned i = 0; i < SUBDRV; i++) begin
      if (arb_grant[i]) begin
        sel_lba = sel_lba | req_lba[i];
        sel_cnt = sel_cnt | req_blk_cnt[i];
      end
    end
  end

  assign ack_g   = |(sd_ack & grant_q);
  assign pending = |(grant_q & (is_wr_q ? req_wr : req_rd));
  assign active  = (state_q == StIssue) || (state_q == StXfer);
  // Block boundary seen in the same cycle as byte 0 so that byte lands in the new block.
  assign wrap    = (state_q == StXfer) && ack_g &&
                   (addr_prev_q == BlkLastByte) && (sd_buff_addr == 8'd0);
  assign blk_eff = (wrap && (blk_idx_q != cnt_q)) ? blk_idx_q + 6'd1 : blk_idx_q;

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    is_wr_d     = is_wr_q;
    blk_idx_d   = blk_idx_q;
    lba_d       = lba_q;
    cnt_d       = cnt_q;
    addr_prev_d = addr_prev_q;
    unique case (state_q)
      StIdle: begin
        if (|arb_req) begin
          grant_d = arb_grant;
          is_wr_d = |(arb_grant & req_wr);
          lba_d   = sel_lba;
          cnt_d   = sel_cnt;
          state_d = StIssue;
        end
      end
      StIssue: begin
        addr_prev_d = '0;
        if (ack_g) begin
          state_d = StXfer;
        end else if (!pending) begin
          state_d = StIdle;
        end
      end
      StXfer: begin
        blk_idx_d   = blk_eff;
        addr_prev_d = sd_buff_addr;
        if (!ack_g) begin
          state_d = StDone;
        end
      end
      StDone: begin
        blk_idx_d   = '0;
        addr_prev_d = '0;
        state_d     = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      grant_q     <= SUBDRV'(1);
      is_wr_q     <= 1'b0;
      blk_idx_q   <= '0;
      lba_q       <= '0;
      cnt_q       <= '0;
      addr_prev_q <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      is_wr_q     <= is_wr_d;
      blk_idx_q   <= blk_idx_d;
      lba_q       <= lba_d;
      cnt_q       <= cnt_d;
      addr_prev_q <= addr_prev_d;
    end
  end

  // Strobes drop immediately if the requester withdraws before the host acks.
  always_comb begin
    sd_rd = '0;
    sd_wr = '0;
    if (state_q == StIssue) begin
      if (is_wr_q) begin
        sd_wr = grant_q & req_wr;
      end else begin
        sd_rd = grant_q & req_rd;
      end
    end
  end

  assign req_ack    = active ? (sd_ack & grant_q) : '0;
  assign buf_we     = active && sd_buff_wr && ack_g && !is_wr_q;
  assign buf_addr   = {blk_eff, sd_buff_addr};
  assign buf_sel    = grant_q;
  assign busy       = (state_q != StIdle);
  assign sd_lba     = lba_q;
  assign sd_blk_cnt = cnt_q;

endmodule

// File: tb/tb_ieeedrv_sdreq.sv
// Directed bench for ieeedrv_sdreq with two sub-drives.
module tb_ieeedrv_sdreq;

  logic        clk_sys;
  logic        reset_n;
  logic [31:0] req_lba     [2];
  logic [5:0]  req_blk_cnt [2];
  logic [1:0]  req_rd, req_wr, req_ack;
  logic [31:0] sd_lba;
  logic [5:0]  sd_blk_cnt;
  logic [1:0]  sd_rd, sd_wr, sd_ack;
  logic [7:0]  sd_buff_addr;
  logic        sd_buff_wr;
  logic [13:0] buf_addr;
  logic        buf_we;
  logic [1:0]  buf_sel;
  logic        busy;

  int errors = 0;
  int checks = 0;

  ieeedrv_sdreq #(
    .SUBDRV (2)
  ) dut (
    .clk_sys      (clk_sys),
    .reset_n      (reset_n),
    .req_lba      (req_lba),
    .req_blk_cnt  (req_blk_cnt),
    .req_rd       (req_rd),
    .req_wr       (req_wr),
    .req_ack      (req_ack),
    .sd_lba       (sd_lba),
    .sd_blk_cnt   (sd_blk_cnt),
    .sd_rd        (sd_rd),
    .sd_wr        (sd_wr),
    .sd_ack       (sd_ack),
    .sd_buff_addr (sd_buff_addr),
    .sd_buff_wr   (sd_buff_wr),
    .buf_addr     (buf_addr),
    .buf_we       (buf_we),
    .buf_sel      (buf_sel),
    .busy         (busy)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #2;
  endtask

  // Host side of a transfer, entered while the DUT sits in ISSUE for drive d.
  task automatic host_xfer(input int d, input int nbytes, input logic rd);
    sd_ack    = '0;
    sd_ack[d] = 1'b1;
    tick();
    req_rd[d] = 1'b0;
    req_wr[d] = 1'b0;
    #1;
    chk("strobe_clr", {30'd0, sd_wr | sd_rd}, 0);
    for (int i = 0; i < nbytes; i++) begin
      sd_buff_addr = 8'(i);
      sd_buff_wr   = 1'b1;
      #1;
      chk("x_addr", {18'd0, buf_addr}, i);
      chk("x_we", {31'd0, buf_we}, {31'd0, rd});
      chk("x_ack", {30'd0, req_ack}, 1 << d);
      tick();
    end
    sd_buff_wr = 1'b0;
    sd_ack     = '0;
    #1;
    chk("x_ack_low", {30'd0, req_ack}, 0);
    tick();
    #1;
    chk("done_busy", {31'd0, busy}, 1);
    tick();
    #1;
    chk("idle_busy", {31'd0, busy}, 0);
  endtask

  initial begin
    reset_n        = 1'b1;
    req_lba[0]     = '0;
    req_lba[1]     = '0;
    req_blk_cnt[0] = '0;
    req_blk_cnt[1] = '0;
    req_rd         = '0;
    req_wr         = '0;
    sd_ack         = '0;
    sd_buff_addr   = '0;
    sd_buff_wr     = 1'b0;
    #1 reset_n = 1'b0;
    #1;
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_sd_rd", {30'd0, sd_rd}, 0);
    chk("rst_sd_wr", {30'd0, sd_wr}, 0);
    chk("rst_lba", sd_lba, 0);
    chk("rst_cnt", {26'd0, sd_blk_cnt}, 0);
    chk("rst_sel", {30'd0, buf_sel}, 1);
    chk("rst_ack", {30'd0, req_ack}, 0);
    chk("rst_we", {31'd0, buf_we}, 0);
    tick();
    tick();
    reset_n = 1'b1;
    tick();

    // 29-block read on drive 0, plus saturation of the block index.
    req_lba[0]     = 32'h1D;
    req_blk_cnt[0] = 6'd28;
    req_rd[0]      = 1'b1;
    tick();
    #1;
    chk("r0_sd_rd", {30'd0, sd_rd}, 1);
    chk("r0_lba", sd_lba, 32'h1D);
    chk("r0_cnt", {26'd0, sd_blk_cnt}, 28);
    chk("r0_sel", {30'd0, buf_sel}, 1);
    chk("r0_busy", {31'd0, busy}, 1);
    sd_ack = 2'b01;
    tick();
    req_rd[0] = 1'b0;
    #1;
    chk("r0_strobe_clr", {30'd0, sd_rd}, 0);
    for (int b = 0; b < 29; b++) begin
      for (int i = 0; i < 256; i++) begin
        sd_buff_addr = 8'(i);
        sd_buff_wr   = 1'b1;
        #1;
        chk("r0_addr", {18'd0, buf_addr}, b * 256 + i);
        chk("r0_we", {31'd0, buf_we}, 1);
        chk("r0_ack", {30'd0, req_ack}, 1);
        tick();
      end
    end
    sd_buff_addr = 8'd0;
    #1;
    chk("r0_sat", {18'd0, buf_addr}, 32'h1C00);
    tick();
    sd_buff_wr = 1'b0;
    sd_ack     = '0;
    tick();
    tick();
    #1;
    chk("r0_idle", {31'd0, busy}, 0);

    // Drive 1 with both rd and wr set: write wins, no buffer writes.
    req_lba[1]     = 32'd768;
    req_blk_cnt[1] = 6'd16;
    req_rd[1]      = 1'b1;
    req_wr[1]      = 1'b1;
    tick();
    #1;
    chk("w1_sd_wr", {30'd0, sd_wr}, 2);
    chk("w1_sd_rd", {30'd0, sd_rd}, 0);
    chk("w1_lba", sd_lba, 768);
    chk("w1_cnt", {26'd0, sd_blk_cnt}, 16);
    chk("w1_sel", {30'd0, buf_sel}, 2);
    host_xfer(1, 16, 1'b0);

    // Simultaneous requests alternate between drives.
    req_lba[0] = 32'd5;
    req_lba[1] = 32'd9;
    req_rd     = 2'b11;
    tick();
    #1;
    chk("rr_a_sel", {30'd0, buf_sel}, 1);
    chk("rr_a_rd", {30'd0, sd_rd}, 1);
    chk("rr_a_lba", sd_lba, 5);
    host_xfer(0, 4, 1'b1);
    tick();
    #1;
    chk("rr_b_sel", {30'd0, buf_sel}, 2);
    chk("rr_b_rd", {30'd0, sd_rd}, 2);
    chk("rr_b_lba", sd_lba, 9);
    host_xfer(1, 4, 1'b1);
    req_rd = 2'b11;
    tick();
    #1;
    chk("rr_c_sel", {30'd0, buf_sel}, 1);
    host_xfer(0, 2, 1'b1);
    tick();
    #1;
    chk("wd_sd_rd", {30'd0, sd_rd}, 2);
    req_rd[1] = 1'b0;
    #1;
    chk("wd_rd_clr", {30'd0, sd_rd}, 0);
    chk("wd_no_ack", {30'd0, req_ack}, 0);
    tick();
    #1;
    chk("wd_idle", {31'd0, busy}, 0);
    chk("wd_rd_idle", {30'd0, sd_rd}, 0);

    // Foreign ack while drive 0 is granted.
    req_lba[0] = 32'h40;
    req_rd[0]  = 1'b1;
    tick();
    sd_ack       = 2'b10;
    sd_buff_wr   = 1'b1;
    sd_buff_addr = 8'd3;
    #1;
    chk("fa_ack", {30'd0, req_ack}, 0);
    chk("fa_we", {31'd0, buf_we}, 0);
    tick();
    #1;
    chk("fa_hold_rd", {30'd0, sd_rd}, 1);
    chk("fa_busy", {31'd0, busy}, 1);
    sd_buff_wr = 1'b0;
    sd_ack     = 2'b11;
    #1;
    chk("fa_both_ack", {30'd0, req_ack}, 1);
    tick();
    req_rd[0]    = 1'b0;
    sd_buff_wr   = 1'b1;
    sd_buff_addr = 8'd0;
    #1;
    chk("fa_x_ack", {30'd0, req_ack}, 1);
    chk("fa_x_we", {31'd0, buf_we}, 1);
    sd_buff_wr = 1'b0;
    sd_ack     = '0;
    tick();
    tick();
    #1;
    chk("fa_idle", {31'd0, busy}, 0);

    // Reset in the middle of block 3.
    req_lba[0]     = 32'h100;
    req_blk_cnt[0] = 6'd5;
    req_rd[0]      = 1'b1;
    tick();
    sd_ack = 2'b01;
    tick();
    for (int n = 0; n < 3 * 256 + 100; n++) begin
      sd_buff_addr = 8'(n);
      sd_buff_wr   = 1'b1;
      tick();
    end
    sd_buff_addr = 8'd100;
    #1;
    chk("mr_addr", {18'd0, buf_addr}, 32'h364);
    reset_n = 1'b0;
    #1;
    chk("mr_busy", {31'd0, busy}, 0);
    chk("mr_we", {31'd0, buf_we}, 0);
    chk("mr_ack", {30'd0, req_ack}, 0);
    chk("mr_rd", {30'd0, sd_rd}, 0);
    chk("mr_lba", sd_lba, 0);
    chk("mr_cnt", {26'd0, sd_blk_cnt}, 0);
    chk("mr_sel", {30'd0, buf_sel}, 1);
    chk("mr_baddr", {18'd0, buf_addr}, 100);
    req_rd[0] = 1'b0;
    reset_n   = 1'b1;
    tick();
    #1;
    chk("mr_stale_ack", {30'd0, req_ack}, 0);
    chk("mr_stale_we", {31'd0, buf_we}, 0);
    chk("mr_stale_busy", {31'd0, busy}, 0);
    sd_ack     = '0;
    sd_buff_wr = 1'b0;
    req_lba[0] = 32'd7;
    req_rd[0]  = 1'b1;
    tick();
    #1;
    chk("mr_new_rd", {30'd0, sd_rd}, 1);
    chk("mr_new_lba", sd_lba, 7);
    host_xfer(0, 8, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
